// File: rtl/dbg_gov_pkg.sv
// rtl/dbg_gov_pkg.sv - shared debug-governor command definitions
// Purpose: command word width, function-bit positions and packer state
//          encoding, shared by the command packer and the governor FSM.
// Ports:   none (package).
package dbg_gov_pkg;

  localparam int CMD_W = 29;

  // Command word bit positions; [12:1] form the function field,
  // [28:13] carry the argument.
  localparam int CMD_CONT       = 0;
  localparam int CMD_PAUSE_RD   = 1;
  localparam int CMD_PAUSE_WR   = 2;
  localparam int CMD_DROP_RD    = 3;
  localparam int CMD_DROP_WR    = 4;
  localparam int CMD_INJ_RD     = 5;
  localparam int CMD_INJ_WR     = 6;
  localparam int CMD_LOG_RD     = 7;
  localparam int CMD_LOG_WR     = 8;
  localparam int CMD_LOG_RADDR  = 9;
  localparam int CMD_LOG_AWADDR = 10;
  localparam int CMD_LOG_RESP   = 11;
  localparam int CMD_INJ_RESP   = 12;
  localparam int CMD_ARG_LSB    = 13;

  typedef enum logic [0:0] {
    PK_COLLECT = 1'b0,
    PK_DISCARD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/dbg_cmd_fifo.sv
// rtl/dbg_cmd_fifo.sv - synchronous command word FIFO
// Purpose: small first-word-fall-through buffer between packer and FSM.
// Ports:   clk, rst (async, active-high)
//          push/din  - write a word (ignored when full)
//          pop       - drop the head word (ignored when empty)
//          dout      - head word, stable until popped
//          full, empty, level - occupancy status
module dbg_cmd_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign level     = r_wr_ptr - r_rd_ptr;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= din;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/dbg_cmd_packer.sv
// rtl/dbg_cmd_packer.sv - host byte stream to governor command word packer
// Purpose: assembles 4-byte little-endian frames into 29-bit commands,
//          rejects malformed/empty frames and queues accepted words.
// Ports:   clk, rst (async, active-high)
//          in_TDATA/in_TVALID/in_TLAST/in_TREADY - host byte stream (slave)
//          cmd_out_TDATA/TVALID/TREADY           - command words (master)
//          fifo_level - buffered words; err_pulse/err_count - rejects
import dbg_gov_pkg::*;

module dbg_cmd_packer #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_TDATA,
  input  logic                     in_TVALID,
  input  logic                     in_TLAST,
  output logic                     in_TREADY,
  output logic [CMD_W-1:0]         cmd_out_TDATA,
  output logic                     cmd_out_TVALID,
  input  logic                     cmd_out_TREADY,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_count
);

  pack_state_e      r_state;
  logic [1:0]       r_idx;
  logic [23:0]      r_shadow;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;

  logic             w_full;
  logic             w_empty;
  logic             w_collect;
  logic             w_last_idx;
  logic             w_xfer;
  logic             w_reserved_ok;
  logic             w_func_ok;
  logic             w_push;
  logic             w_reject;
  logic [CMD_W-1:0] w_word;

  assign w_collect  = (r_state == PK_COLLECT);
  assign w_last_idx = (r_idx == 2'd3);

  // Stall only the frame-completing byte when there is no room for its word.
  assign in_TREADY  = !w_collect || !(w_last_idx && w_full);
  assign w_xfer     = in_TVALID && in_TREADY;

  // Byte 3 is never latched: the word is formed from the live byte.
  assign w_word        = {in_TDATA[4:0], r_shadow};
  assign w_reserved_ok = (in_TDATA[7:5] == 3'b000);
  assign w_func_ok     = |w_word[CMD_INJ_RESP:CMD_PAUSE_RD];

  assign w_push   = w_xfer && w_collect && w_last_idx && in_TLAST &&
                    w_reserved_ok && w_func_ok;
  assign w_reject = w_xfer && w_collect &&
                    (in_TLAST ? !(w_last_idx && w_reserved_ok && w_func_ok)
                              : w_last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PK_COLLECT;
      r_idx       <= 2'd0;
      r_shadow    <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_reject;
      if (w_reject && (r_err_count != '1))
        r_err_count <= r_err_count + ERR_W'(1);

      if (w_xfer) begin
        if (w_collect) begin
          if (in_TLAST || w_last_idx) begin
            r_idx <= 2'd0;
            // Overlong frame: swallow the rest up to its TLAST silently.
            if (!in_TLAST) r_state <= PK_DISCARD;
          end else begin
            r_shadow[8*r_idx +: 8] <= in_TDATA;
            r_idx                  <= r_idx + 2'd1;
          end
        end else if (in_TLAST) begin
          r_state <= PK_COLLECT;
        end
      end
    end
  end

  assign err_pulse      = r_err_pulse;
  assign err_count      = r_err_count;
  assign cmd_out_TVALID = !w_empty;

  dbg_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (cmd_out_TVALID && cmd_out_TREADY),
    .din   (w_word),
    .dout  (cmd_out_TDATA),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_dbg_cmd_packer.sv
// tb/tb_dbg_cmd_packer.sv - scoreboard bench for dbg_cmd_packer
module tb_dbg_cmd_packer;

  localparam int DEPTH = 4;
  localparam int ERR_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_TDATA;
  logic              in_TVALID;
  logic              in_TLAST;
  logic              in_TREADY;
  logic [28:0]       cmd_out_TDATA;
  logic              cmd_out_TVALID;
  logic              cmd_out_TREADY;
  logic [LW-1:0]     fifo_level;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;

  int          checks    = 0;
  int          failures  = 0;
  int          pulse_cnt = 0;
  logic [28:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [28:0] prev_data  = '0;

  always #5 clk = ~clk;

  dbg_cmd_packer #(
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_TDATA       (in_TDATA),
    .in_TVALID      (in_TVALID),
    .in_TLAST       (in_TLAST),
    .in_TREADY      (in_TREADY),
    .cmd_out_TDATA  (cmd_out_TDATA),
    .cmd_out_TVALID (cmd_out_TVALID),
    .cmd_out_TREADY (cmd_out_TREADY),
    .fifo_level     (fifo_level),
    .err_pulse      (err_pulse),
    .err_count      (err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every word transfer and checks that a
  // stalled word does not change.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) chk("tdata_stable", 32'(cmd_out_TDATA), 32'(prev_data));
      if (cmd_out_TVALID && cmd_out_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h required=none", cmd_out_TDATA);
        end else begin
          chk("word", 32'(cmd_out_TDATA), 32'(exp_q.pop_front()));
        end
      end
      if (err_pulse) pulse_cnt++;
      prev_stall = cmd_out_TVALID && !cmd_out_TREADY;
      prev_data  = cmd_out_TDATA;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the byte transfer.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int k;
    in_TDATA  = b;
    in_TLAST  = last;
    in_TVALID = 1'b1;
    k = 0;
    while (!in_TREADY && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_TREADY) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout actual=stalled required=accepted");
    end
    @(posedge clk); #1;
    in_TVALID = 1'b0;
    in_TLAST  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    send_byte(b3, 1'b1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    in_TVALID      = 1'b0;
    in_TDATA       = 8'h00;
    in_TLAST       = 1'b0;
    cmd_out_TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("rst_in_tready", 32'(in_TREADY), 32'd1);
    chk("rst_tvalid", 32'(cmd_out_TVALID), 32'd0);
    chk("rst_tdata", 32'(cmd_out_TDATA), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    // Basic frame, one-cycle latency.
    exp_q.push_back(29'h0000003);
    send_frame(8'h03, 8'h00, 8'h00, 8'h00);
    chk("latency_tvalid", 32'(cmd_out_TVALID), 32'd1);
    drain();
    chk("t1_err_count", 32'(err_count), 32'd0);

    // Empty function field.
    send_frame(8'h01, 8'h00, 8'h00, 8'h00);
    chk("t2_err_pulse", 32'(err_pulse), 32'd1);
    @(posedge clk); #1;
    chk("t2_err_pulse_end", 32'(err_pulse), 32'd0);
    chk("t2_err_count", 32'(err_count), 32'd1);
    chk("t2_no_word", 32'(cmd_out_TVALID), 32'd0);

    // Short frame, then a good one.
    send_byte(8'h09, 1'b0);
    send_byte(8'h10, 1'b1);
    chk("t3_err_pulse", 32'(err_pulse), 32'd1);
    exp_q.push_back(29'h0001009);
    send_frame(8'h09, 8'h10, 8'h00, 8'h00);
    drain();
    chk("t3_err_count", 32'(err_count), 32'd2);

    // Reserved bits set.
    send_frame(8'h03, 8'h00, 8'h00, 8'h20);
    chk("t4_rsv_pulse", 32'(err_pulse), 32'd1);
    @(posedge clk); #1;
    chk("t4_rsv_count", 32'(err_count), 32'd3);

    // Overlong frame: one error, junk discarded up to TLAST.
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("t4_long_pulse", 32'(err_pulse), 32'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    chk("t4_discard_no_pulse", 32'(err_pulse), 32'd0);
    chk("t4_long_count", 32'(err_count), 32'd4);
    exp_q.push_back(29'h1000005);
    send_frame(8'h05, 8'h00, 8'h00, 8'h01);
    drain();

    // Backpressure: fill the FIFO, stall the 5th frame's last byte.
    cmd_out_TREADY = 1'b0;
    exp_q.push_back(29'h0000003);
    exp_q.push_back(29'h0000007);
    exp_q.push_back(29'h0002003);
    exp_q.push_back(29'h1FFFFFFF);
    exp_q.push_back(29'h000000A);
    send_frame(8'h03, 8'h00, 8'h00, 8'h00);
    send_frame(8'h07, 8'h00, 8'h00, 8'h00);
    send_frame(8'h03, 8'h20, 8'h00, 8'h00);
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'h1F);
    chk("t5_level_full", 32'(fifo_level), 32'd4);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    fork
      send_byte(8'h00, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("t5_in_tready_stall", 32'(in_TREADY), 32'd0);
        chk("t5_level_stall", 32'(fifo_level), 32'd4);
        cmd_out_TREADY = 1'b1;
      end
    join
    drain();
    chk("t5_level_empty", 32'(fifo_level), 32'd0);

    // Reset with two buffered words and a half frame.
    cmd_out_TREADY = 1'b0;
    send_frame(8'h03, 8'h00, 8'h00, 8'h00);
    send_frame(8'h05, 8'h00, 8'h00, 8'h00);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("t6_level_pre", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    #1;
    chk("t6_tvalid_rst", 32'(cmd_out_TVALID), 32'd0);
    chk("t6_level_rst", 32'(fifo_level), 32'd0);
    chk("t6_err_count_rst", 32'(err_count), 32'd0);
    chk("t6_in_tready_rst", 32'(in_TREADY), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_out_TREADY = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(29'h0002211);
    send_frame(8'h11, 8'h22, 8'h00, 8'h00);
    drain();

    chk("final_pulses", 32'(pulse_cnt), 32'd4);
    chk("final_tvalid", 32'(cmd_out_TVALID), 32'd0);
    chk("final_err_count", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
